motor_mux_gen: RTL and testbench

- Parametrised column/row sequencer for the motor driver array. Successor to the fixed 16-row, 4-subcolumn multiplexer.
- Row count, group size, column count and counter widths are parameters.
- Adds idle-group skipping, abort, and a sleep/step writeback handshake.
- Sits between the register-file front end (fetch/writeback handshakes) and the motor_driver instances. Drivers are external; this block only sequences them.

---
 rtl/motor_mux_gen_pkg.sv | 19 +
 rtl/motor_mux_gen_if.sv | 32 +++
 rtl/motor_mux_gen_throttle.sv | 28 ++
 rtl/motor_mux_gen.sv | 186 ++++++++++++++++++
 tb/tb_motor_mux_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_mux_gen_pkg.sv
// Shared types for the motor driver column/row sequencer.
package motor_mux_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_GROUP_START,
    ST_DRIVE,
    ST_THROTTLE,
    ST_WRITEBACK,
    ST_NEXT_COL,
    ST_DONE
  } mmg_state_t;

  localparam int MMG_CNT_W = 16;

  typedef logic [MMG_CNT_W-1:0] cnt_vec_t;

endpackage

// File: rtl/motor_mux_gen_if.sv
// Register-file side of the sequencer: column fetch and count writeback handshakes.
interface motor_mux_gen_if #(
  parameter int MOTOR_ROWS = 16,
  parameter int MOTOR_COLS = 8,
  parameter int CNT_W      = 16
);
  localparam int COL_W = (MOTOR_COLS > 1) ? $clog2(MOTOR_COLS) : 1;

  logic                        fetch_req;
  logic [COL_W-1:0]            fetch_col;
  logic                        fetch_ack;
  logic [MOTOR_ROWS*CNT_W-1:0] fetch_steps;
  logic [MOTOR_ROWS*CNT_W-1:0] fetch_sleeps;
  logic [MOTOR_ROWS-1:0]       fetch_en;
  logic [MOTOR_ROWS-1:0]       fetch_dir;

  logic                        wb_req;
  logic [COL_W-1:0]            wb_col;
  logic [MOTOR_ROWS*CNT_W-1:0] wb_steps;
  logic [MOTOR_ROWS*CNT_W-1:0] wb_sleeps;
  logic                        wb_ack;

  modport master (
    output fetch_req, fetch_col, wb_req, wb_col, wb_steps, wb_sleeps,
    input  fetch_ack, fetch_steps, fetch_sleeps, fetch_en, fetch_dir, wb_ack
  );

  modport slave (
    input  fetch_req, fetch_col, wb_req, wb_col, wb_steps, wb_sleeps,
    output fetch_ack, fetch_steps, fetch_sleeps, fetch_en, fetch_dir, wb_ack
  );
endinterface

// File: rtl/motor_mux_gen_throttle.sv
// Saturating 1 MHz tick counter that sets the minimum period of one driver group.
module mmg_throttle #(
  parameter int STEP_LEN_W = 16
) (
  input  logic                  clock_16mhz,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  tick,
  input  logic [STEP_LEN_W-1:0] len,
  output logic                  done
);

  logic [STEP_LEN_W-1:0] cnt;

  function automatic logic [STEP_LEN_W-1:0] sat_inc(input logic [STEP_LEN_W-1:0] v);
    return (&v) ? v : v + STEP_LEN_W'(1);
  endfunction

  // A tick landing on the clear cycle already counts toward the period.
  always_ff @(posedge clock_16mhz or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= STEP_LEN_W'(tick);
    else if (tick) cnt <= sat_inc(cnt);
  end

  assign done = (cnt >= len);

endmodule

// File: rtl/motor_mux_gen.sv
// Column/row sequencer: fetches a column, starts driver groups, throttles, writes counts back.
module motor_mux_gen
  import motor_mux_gen_pkg::*;
#(
  parameter int MOTOR_ROWS       = 16,
  parameter int MOTOR_COLS       = 8,
  parameter int GROUP_SIZE       = 4,
  parameter int CNT_W            = 16,
  parameter int STEP_LEN_W       = 16,
  parameter int SKIP_IDLE_GROUPS = 1
) (
  input  logic                  clock_16mhz,
  input  logic                  reset_n,
  input  logic                  tick_1mhz,
  input  logic                  go,
  input  logic                  abort,
  input  logic [STEP_LEN_W-1:0] step_len,
  output logic                  ready,
  motor_mux_gen_if.master       rf,
  output logic [MOTOR_ROWS-1:0] drv_start,
  output logic [MOTOR_ROWS-1:0] drv_dir,
  input  logic [MOTOR_ROWS-1:0] drv_ready,
  output logic [MOTOR_COLS-1:0] col_en,
  output logic                  col_finished,
  output logic                  move_done
);

  localparam int NUM_GROUPS = MOTOR_ROWS / GROUP_SIZE;
  localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int COL_W      = (MOTOR_COLS > 1) ? $clog2(MOTOR_COLS) : 1;

  mmg_state_t                  state;
  logic [STEP_LEN_W-1:0]       step_len_q;
  logic [COL_W-1:0]            col;
  logic [GRP_W-1:0]            grp;
  logic                        any_left;
  logic                        abort_seen;
  logic                        drive_first;
  logic [MOTOR_ROWS*CNT_W-1:0] steps_q;
  logic [MOTOR_ROWS*CNT_W-1:0] sleeps_q;
  logic [MOTOR_ROWS-1:0]       en_q;
  logic [MOTOR_ROWS-1:0]       dir_q;
  logic [MOTOR_ROWS-1:0]       started;

  logic [MOTOR_ROWS-1:0]       active;
  logic [MOTOR_ROWS-1:0]       grp_mask;
  logic [MOTOR_ROWS-1:0]       grp_start;
  logic [MOTOR_ROWS*CNT_W-1:0] upd_steps;
  logic [MOTOR_ROWS*CNT_W-1:0] upd_sleeps;
  logic                        upd_left;
  logic                        grp_ready;
  logic                        last_grp;
  logic                        last_col;
  logic                        thr_done;

  // A started row consumes a step; an idle enabled row burns one sleep instead.
  always_comb begin
    active     = '0;
    upd_steps  = steps_q;
    upd_sleeps = sleeps_q;
    upd_left   = 1'b0;
    for (int r = 0; r < MOTOR_ROWS; r++) begin
      active[r] = en_q[r] && (steps_q[r*CNT_W +: CNT_W] != '0)
                          && (sleeps_q[r*CNT_W +: CNT_W] == '0);
      if (started[r] && (steps_q[r*CNT_W +: CNT_W] != '0))
        upd_steps[r*CNT_W +: CNT_W] = steps_q[r*CNT_W +: CNT_W] - CNT_W'(1);
      else if (en_q[r] && (sleeps_q[r*CNT_W +: CNT_W] != '0))
        upd_sleeps[r*CNT_W +: CNT_W] = sleeps_q[r*CNT_W +: CNT_W] - CNT_W'(1);
      upd_left = upd_left | (en_q[r] && (upd_steps[r*CNT_W +: CNT_W] != '0));
    end
  end

  assign grp_mask  = MOTOR_ROWS'({GROUP_SIZE{1'b1}}) << (grp * GROUP_SIZE);
  assign grp_start = active & grp_mask;
  assign grp_ready = &(drv_ready | ~grp_mask);
  assign last_grp  = (grp == GRP_W'(NUM_GROUPS - 1));
  assign last_col  = (col == COL_W'(MOTOR_COLS - 1));

  mmg_throttle #(.STEP_LEN_W(STEP_LEN_W)) u_throttle (
    .clock_16mhz (clock_16mhz),
    .reset_n     (reset_n),
    .clr         (state == ST_GROUP_START),
    .tick        (tick_1mhz),
    .len         (step_len_q),
    .done        (thr_done)
  );

  always_ff @(posedge clock_16mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      step_len_q  <= '0;
      col         <= '0;
      grp         <= '0;
      any_left    <= 1'b0;
      abort_seen  <= 1'b0;
      drive_first <= 1'b0;
      steps_q     <= '0;
      sleeps_q    <= '0;
      en_q        <= '0;
      dir_q       <= '0;
      started     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (go) begin
          step_len_q <= step_len;
          col        <= '0;
          any_left   <= 1'b0;
          abort_seen <= 1'b0;
          state      <= ST_FETCH;
        end
        ST_FETCH: if (rf.fetch_ack) begin
          steps_q  <= rf.fetch_steps;
          sleeps_q <= rf.fetch_sleeps;
          en_q     <= rf.fetch_en;
          dir_q    <= rf.fetch_dir;
          started  <= '0;
          grp      <= '0;
          state    <= ST_GROUP_START;
        end
        ST_GROUP_START: begin
          started <= started | grp_start;
          if ((SKIP_IDLE_GROUPS != 0) && (grp_start == '0)) begin
            if (last_grp) state <= ST_WRITEBACK;
            else          grp   <= grp + GRP_W'(1);
          end else begin
            drive_first <= 1'b1;
            state       <= ST_DRIVE;
          end
        end
        // Drivers only drop ready the cycle after start, so the first DRIVE cycle is blind.
        ST_DRIVE: begin
          if (abort) abort_seen <= 1'b1;
          drive_first <= 1'b0;
          if (!drive_first && grp_ready) state <= ST_THROTTLE;
        end
        ST_THROTTLE: begin
          if (abort) abort_seen <= 1'b1;
          if (thr_done) begin
            if (last_grp || abort_seen || abort) begin
              state <= ST_WRITEBACK;
            end else begin
              grp   <= grp + GRP_W'(1);
              state <= ST_GROUP_START;
            end
          end
        end
        ST_WRITEBACK: if (rf.wb_ack) begin
          any_left <= any_left | upd_left;
          state    <= ST_NEXT_COL;
        end
        ST_NEXT_COL: begin
          if (abort_seen) begin
            state <= ST_DONE;
          end else if (last_col) begin
            if (any_left) begin
              col      <= '0;
              any_left <= 1'b0;
              state    <= ST_FETCH;
            end else begin
              state <= ST_DONE;
            end
          end else begin
            col   <= col + COL_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready        = (state == ST_IDLE);
  assign rf.fetch_req = (state == ST_FETCH);
  assign rf.fetch_col = (state == ST_FETCH) ? col : '0;
  assign rf.wb_req    = (state == ST_WRITEBACK);
  assign rf.wb_col    = (state == ST_WRITEBACK) ? col : '0;
  assign rf.wb_steps  = (state == ST_WRITEBACK) ? upd_steps : '0;
  assign rf.wb_sleeps = (state == ST_WRITEBACK) ? upd_sleeps : '0;
  assign drv_start    = (state == ST_GROUP_START) ? grp_start : '0;
  assign drv_dir      = dir_q;
  assign col_en       = ((state == ST_IDLE) || (state == ST_DONE)) ? '0 : (MOTOR_COLS'(1) << col);
  assign col_finished = (state == ST_NEXT_COL);
  assign move_done    = (state == ST_DONE);

endmodule

// File: tb/tb_motor_mux_gen.sv
// Directed bench for motor_mux_gen with a register-file responder and a simple driver model.
module tb_motor_mux_gen;
  import motor_mux_gen_pkg::*;

  localparam int ROWS = 16;
  localparam int COLS = 2;

  logic             clock_16mhz = 1'b0;
  logic             reset_n     = 1'b0;
  logic             tick_1mhz   = 1'b0;
  logic             go          = 1'b0;
  logic             abort       = 1'b0;
  logic [15:0]      step_len    = '0;
  logic             ready;
  logic [ROWS-1:0]  drv_start;
  logic [ROWS-1:0]  drv_dir;
  logic [ROWS-1:0]  drv_ready   = '1;
  logic [COLS-1:0]  col_en;
  logic             col_finished;
  logic             move_done;

  motor_mux_gen_if #(.MOTOR_ROWS(ROWS), .MOTOR_COLS(COLS), .CNT_W(16)) rf_if ();

  motor_mux_gen #(
    .MOTOR_ROWS(ROWS), .MOTOR_COLS(COLS), .GROUP_SIZE(4),
    .CNT_W(16), .STEP_LEN_W(16), .SKIP_IDLE_GROUPS(1)
  ) dut (
    .clock_16mhz  (clock_16mhz),
    .reset_n      (reset_n),
    .tick_1mhz    (tick_1mhz),
    .go           (go),
    .abort        (abort),
    .step_len     (step_len),
    .ready        (ready),
    .rf           (rf_if),
    .drv_start    (drv_start),
    .drv_dir      (drv_dir),
    .drv_ready    (drv_ready),
    .col_en       (col_en),
    .col_finished (col_finished),
    .move_done    (move_done)
  );

  cnt_vec_t          mem_steps  [COLS][ROWS];
  cnt_vec_t          mem_sleeps [COLS][ROWS];
  logic [ROWS-1:0]   mem_en     [COLS];
  logic [ROWS-1:0]   mem_dir    [COLS];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_div = 4;
  int busy_len = 1;
  int wb_hold  = 0;
  int wb_wait  = 0;
  int busy [ROWS];
  int start_cnt [ROWS];
  int fin_cnt  = 0;
  int done_cnt = 0;
  int fc, wc;
  logic [ROWS-1:0] pend;
  logic [15:0]     exp_m;

  int              pulse_t  [$];
  logic [ROWS-1:0] pulse_v  [$];
  logic [ROWS-1:0] pulse_d  [$];
  int              pulse_wb [$];
  int              wb_col_q [$];
  logic [ROWS*16-1:0] wb_st_q [$];
  logic [ROWS*16-1:0] wb_sl_q [$];

  initial forever #5 clock_16mhz = ~clock_16mhz;

  initial forever begin
    @(posedge clock_16mhz);
    #1;
    cyc++;
    tick_1mhz = (tick_div != 0) && (cyc % tick_div == 0);
  end

  // Drivers: ready drops the cycle after a start and stays low for busy_len cycles.
  initial begin
    for (int r = 0; r < ROWS; r++) busy[r] = 0;
    forever begin
      @(negedge clock_16mhz);
      pend = drv_start;
      @(posedge clock_16mhz);
      #1;
      for (int r = 0; r < ROWS; r++) begin
        if (!reset_n) busy[r] = 0;
        else if (busy[r] > 0) busy[r] = busy[r] - 1;
        if (pend[r] && reset_n) busy[r] = busy_len;
        drv_ready[r] = (busy[r] == 0);
      end
    end
  end

  // Register-file responder and event log.
  initial begin
    rf_if.fetch_ack = 1'b0;
    rf_if.wb_ack = 1'b0;
    rf_if.fetch_steps = '0;
    rf_if.fetch_sleeps = '0;
    rf_if.fetch_en = '0;
    rf_if.fetch_dir = '0;
    forever begin
      @(negedge clock_16mhz);
      if (drv_start != '0) begin
        pulse_t.push_back(cyc);
        pulse_v.push_back(drv_start);
        pulse_d.push_back(drv_dir);
        pulse_wb.push_back(wb_col_q.size());
        for (int r = 0; r < ROWS; r++) if (drv_start[r]) start_cnt[r]++;
      end
      if (col_finished) fin_cnt++;
      if (move_done) done_cnt++;
      if (rf_if.fetch_req && !rf_if.fetch_ack) begin
        fc = int'(rf_if.fetch_col);
        for (int r = 0; r < ROWS; r++) begin
          rf_if.fetch_steps[r*16 +: 16]  = mem_steps[fc][r];
          rf_if.fetch_sleeps[r*16 +: 16] = mem_sleeps[fc][r];
        end
        rf_if.fetch_en  = mem_en[fc];
        rf_if.fetch_dir = mem_dir[fc];
        rf_if.fetch_ack = 1'b1;
      end else begin
        rf_if.fetch_ack = 1'b0;
      end
      if (rf_if.wb_req && !rf_if.wb_ack) begin
        if (wb_wait >= wb_hold) begin
          wc = int'(rf_if.wb_col);
          for (int r = 0; r < ROWS; r++) begin
            mem_steps[wc][r]  = rf_if.wb_steps[r*16 +: 16];
            mem_sleeps[wc][r] = rf_if.wb_sleeps[r*16 +: 16];
          end
          wb_col_q.push_back(wc);
          wb_st_q.push_back(rf_if.wb_steps);
          wb_sl_q.push_back(rf_if.wb_sleeps);
          rf_if.wb_ack = 1'b1;
          wb_wait = 0;
        end else begin
          wb_wait++;
        end
      end else begin
        rf_if.wb_ack = 1'b0;
      end
    end
  end

  function automatic logic [15:0] row_of(input logic [ROWS*16-1:0] v, input int r);
    return v[r*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_col(input int c, input logic [ROWS-1:0] en, input int st, input int sl);
    for (int r = 0; r < ROWS; r++) begin
      mem_steps[c][r]  = cnt_vec_t'(st);
      mem_sleeps[c][r] = cnt_vec_t'(sl);
    end
    mem_en[c]  = en;
    mem_dir[c] = (c == 0) ? 16'hA5A5 : 16'h5A5A;
  endtask

  task automatic clear_logs();
    pulse_t.delete(); pulse_v.delete(); pulse_d.delete(); pulse_wb.delete();
    wb_col_q.delete(); wb_st_q.delete(); wb_sl_q.delete();
    for (int r = 0; r < ROWS; r++) start_cnt[r] = 0;
    fin_cnt = 0; done_cnt = 0; wb_wait = 0;
  endtask

  task automatic start_move(input int sl);
    @(negedge clock_16mhz);
    step_len = 16'(sl);
    go = 1'b1;
    @(negedge clock_16mhz);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clock_16mhz);
      n++;
    end
    @(negedge clock_16mhz);
    chk({tag, " move_done"}, done_cnt, 1);
    chk({tag, " ready"}, ready, 1);
  endtask

  initial begin
    int n;
    int gap;
    logic [ROWS*16-1:0] ws;
    logic [COLS-1:0] ce;
    logic stable;

    // Reset state.
    repeat (3) @(negedge clock_16mhz);
    chk("rst ready", ready, 1);
    chk("rst fetch_req", rf_if.fetch_req, 0);
    chk("rst wb_req", rf_if.wb_req, 0);
    chk("rst col_en", col_en, 0);
    chk("rst drv_start", drv_start, 0);
    chk("rst move_done", move_done, 0);
    reset_n = 1'b1;

    // All rows one step, 3-tick throttle.
    fill_col(0, '1, 1, 0);
    fill_col(1, '1, 1, 0);
    clear_logs();
    tick_div = 4; busy_len = 1;
    start_move(3);
    wait_done("t1");
    chk("t1 pulses", pulse_v.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_m = 16'h000F << (4 * (i % 4));
      chk("t1 group bits", pulse_v[i], exp_m);
    end
    chk("t1 dir col0", pulse_d[0], 16'hA5A5);
    chk("t1 dir col1", pulse_d[4], 16'h5A5A);
    chk("t1 starts row0", start_cnt[0], 2);
    chk("t1 starts row15", start_cnt[15], 2);
    chk("t1 wb count", wb_col_q.size(), 2);
    chk("t1 wb col1", wb_col_q[1], 1);
    chk("t1 wb steps col0 zero", |wb_st_q[0], 0);
    chk("t1 wb steps col1 zero", |wb_st_q[1], 0);
    chk("t1 col_finished", fin_cnt, 2);
    gap = pulse_t[1] - pulse_t[0];
    chk("t1 group period", (gap >= 10 && gap <= 13), 1);

    // Single active row 9, two passes, idle groups skipped.
    fill_col(0, 16'h0200, 0, 0);
    mem_steps[0][9] = 16'd2;
    fill_col(1, '0, 0, 0);
    clear_logs();
    start_move(3);
    wait_done("t2");
    chk("t2 pulses", pulse_v.size(), 2);
    chk("t2 pulse0", pulse_v[0], 16'h0200);
    chk("t2 pulse1", pulse_v[1], 16'h0200);
    chk("t2 wb count", wb_col_q.size(), 4);
    chk("t2 wb pass2 col", wb_col_q[2], 0);
    chk("t2 row9 pass1", row_of(wb_st_q[0], 9), 1);
    chk("t2 row9 pass2", row_of(wb_st_q[2], 9), 0);
    chk("t2 col_finished", fin_cnt, 4);

    // Row 5 sleeps two passes before its single step.
    fill_col(0, 16'h0020, 0, 0);
    mem_steps[0][5] = 16'd1;
    mem_sleeps[0][5] = 16'd2;
    fill_col(1, '0, 0, 0);
    clear_logs();
    start_move(0);
    wait_done("t3");
    chk("t3 wb count", wb_col_q.size(), 6);
    chk("t3 sleeps pass1", row_of(wb_sl_q[0], 5), 1);
    chk("t3 steps pass1", row_of(wb_st_q[0], 5), 1);
    chk("t3 sleeps pass2", row_of(wb_sl_q[2], 5), 0);
    chk("t3 steps pass3", row_of(wb_st_q[4], 5), 0);
    chk("t3 pulses", pulse_v.size(), 1);
    chk("t3 pulse bits", pulse_v[0], 16'h0020);
    chk("t3 start after 2 passes", pulse_wb[0], 4);

    // Abort during group 1 of column 0.
    fill_col(0, '1, 5, 0);
    fill_col(1, '1, 5, 0);
    clear_logs();
    start_move(0);
    n = 0;
    while (drv_start !== 16'h00F0 && n < 500) begin
      @(negedge clock_16mhz);
      n++;
    end
    chk("t4 group1 start", drv_start, 16'h00F0);
    @(negedge clock_16mhz);
    abort = 1'b1;
    @(negedge clock_16mhz);
    abort = 1'b0;
    wait_done("t4");
    chk("t4 pulses", pulse_v.size(), 2);
    chk("t4 starts row4", start_cnt[4], 1);
    chk("t4 starts row8", start_cnt[8], 0);
    chk("t4 wb count", wb_col_q.size(), 1);
    chk("t4 wb col", wb_col_q[0], 0);
    chk("t4 row0 steps", row_of(wb_st_q[0], 0), 4);
    chk("t4 row7 steps", row_of(wb_st_q[0], 7), 4);
    chk("t4 row8 steps", row_of(wb_st_q[0], 8), 5);
    chk("t4 row15 steps", row_of(wb_st_q[0], 15), 5);

    // Writeback held off for 20 cycles.
    fill_col(0, '1, 1, 0);
    fill_col(1, '1, 1, 0);
    clear_logs();
    wb_hold = 20;
    start_move(0);
    n = 0;
    while (rf_if.wb_req !== 1'b1 && n < 500) begin
      @(negedge clock_16mhz);
      n++;
    end
    chk("t5 wb_req seen", rf_if.wb_req, 1);
    ws = rf_if.wb_steps;
    ce = col_en;
    stable = 1'b1;
    repeat (18) begin
      @(negedge clock_16mhz);
      if (rf_if.wb_req !== 1'b1 || rf_if.wb_steps !== ws || col_en !== ce) stable = 1'b0;
    end
    chk("t5 hold stable", stable, 1);
    chk("t5 col_en", ce, 2'b01);
    chk("t5 wb row0", row_of(ws, 0), 0);
    wait_done("t5");
    chk("t5 wb count", wb_col_q.size(), 2);
    wb_hold = 0;

    // Reset asserted mid-DRIVE.
    fill_col(0, '1, 3, 0);
    fill_col(1, '1, 3, 0);
    clear_logs();
    start_move(0);
    n = 0;
    while (drv_start == '0 && n < 500) begin
      @(negedge clock_16mhz);
      n++;
    end
    chk("t5r start seen", drv_start != '0, 1);
    @(negedge clock_16mhz);
    reset_n = 1'b0;
    #1;
    chk("t5r ready", ready, 1);
    chk("t5r fetch_req", rf_if.fetch_req, 0);
    chk("t5r wb_req", rf_if.wb_req, 0);
    chk("t5r col_en", col_en, 0);
    chk("t5r drv_start", drv_start, 0);
    chk("t5r drv_dir", drv_dir, 0);
    @(negedge clock_16mhz);
    reset_n = 1'b1;
    repeat (10) @(negedge clock_16mhz);
    chk("t5r no writeback", wb_col_q.size(), 0);
    chk("t5r idle", ready, 1);

    // Zero step_len, drivers ready two cycles after start.
    fill_col(0, '1, 1, 0);
    fill_col(1, '1, 1, 0);
    clear_logs();
    busy_len = 1;
    start_move(0);
    wait_done("t6");
    chk("t6 pulses", pulse_v.size(), 8);
    chk("t6 period g0-g1", pulse_t[1] - pulse_t[0], 4);
    chk("t6 period g2-g3", pulse_t[3] - pulse_t[2], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
